regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning 1 = zero all 32 registers after reset via the write port, 0 = skip clearing.
REQ-002 The block SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports a_valid, a_reg, a_data  input  1/5/32  requester A (ALU writeback) write request: valid, destination register, data.
REQ-005 The block SHALL have port a_ready  output  1  requester A accepted this cycle when a_valid and a_ready are both high.
REQ-006 The block SHALL have ports b_valid, b_reg, b_data  input  1/5/32, and b_ready  output  1, meaning the same as for A for requester B (load writeback).
REQ-007 The block SHALL have ports dR, wData, wEnable  output  5/32/1  register-file write port, all registered.
REQ-008 The block SHALL have port busy  output  1  high while the clear sequence runs.
REQ-009 The block SHALL have port conflict_cnt  output  16  saturating count of RUN cycles with a_valid and b_valid both high.

Function
REQ-010 The FSM SHALL have two states, CLEAR and RUN, with a 5-bit clear counter.
REQ-011 CLEAR, per edge: load wEnable=1, dR=counter, wData=0; increment counter; at counter=31 load dR=31 and go to RUN.
REQ-012 The clear sequence SHALL produce exactly 32 consecutive wEnable=1 cycles, covering registers 0..31 in ascending order.
REQ-013 In CLEAR, a_ready=b_ready=0 and busy=1; in RUN, busy=0.
REQ-014 In RUN, readies SHALL be combinational from the valids and the last_grant register: only A valid gives a_ready=1; only B valid gives b_ready=1; both valid gives a_ready=1 only if last_grant=B, else b_ready=1.
REQ-015 At most one of a_ready, b_ready SHALL be high in any cycle, and neither SHALL be high when its own valid is low.
REQ-016 last_grant SHALL update to the accepted requester on every accept, hold otherwise, and reset to B so that A wins the first tie.
REQ-017 An accept at edge N SHALL load dR/wData from the winner, with wEnable=1 in the following cycle (latency 1).
REQ-018 When the accepted register is 0, the handshake SHALL complete but wEnable SHALL load 0, so $0 is never written in RUN.
REQ-019 RUN with no accept SHALL load wEnable=0 while dR and wData hold their values.
REQ-020 A sustained contention SHALL alternate A,B,A,B...; throughput SHALL be one write per cycle.
REQ-021 conflict_cnt SHALL increment only in RUN cycles with both valids high and saturate at 16'hFFFF (no wrap).
REQ-022 Inputs while a requester's ready=0 SHALL be ignored; the requester holds its request (no internal buffering).

Reset
REQ-023 An edge with RST=1 SHALL set wEnable=0, dR=0, wData=0, last_grant=B, conflict_cnt=0, and counter=0.
REQ-024 On that edge the state SHALL go to CLEAR when CLEAR_ON_RESET=1, else to RUN.
REQ-025 While RST=1, a_ready=b_ready=0; busy=1 when CLEAR_ON_RESET=1, else busy=0.
REQ-026 RST asserted mid-CLEAR SHALL restart the clear from register 0.
REQ-027 RST asserted in RUN SHALL drop any in-flight write: wEnable=0 at the next cycle.

Verification
REQ-028 Reset release, CLEAR_ON_RESET=1 -> wEnable=1 for 32 cycles with dR=0..31 and wData=0, busy=1 throughout; first ready appears the cycle after dR=31.
REQ-029 RUN, only A valid: a_reg=5, a_data=32'hDEADBEEF for one cycle -> a_ready=1; next cycle wEnable=1, dR=5, wData=DEADBEEF; following cycle wEnable=0.
REQ-030 RUN, A and B valid for 4 cycles after reset (A reg 1, B reg 2) -> grant order A,B,A,B; dR sequence 1,2,1,2; conflict_cnt=4.
REQ-031 RUN, B writes reg 0 with data 32'h1234 -> b_ready=1; next cycle wEnable=0.
REQ-032 RST pulsed at clear counter=10 -> next writes restart at dR=0 and continue to 31; a 20-cycle RST in RUN -> conflict_cnt=0, wEnable=0.
REQ-033 Both valid held for 65540 cycles -> conflict_cnt stays 16'hFFFF after saturation.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: clears all registers after reset, then
// merges ALU (A) and load (B) writebacks into one registered write port.
module regfile_wb_arbiter #(
  parameter logic CLEAR_ON_RESET = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic [4:0]  dR,
  output logic [31:0] wData,
  output logic        wEnable,
  output logic        busy,
  output logic [15:0] conflict_cnt
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        last_b;
  logic        both;
  logic        acc_a;
  logic        acc_b;

  assign both  = a_valid & b_valid;
  assign acc_a = a_valid & a_ready;
  assign acc_b = b_valid & b_ready;
  assign busy  = RST ? CLEAR_ON_RESET : (state == CLEAR);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!RST && state == RUN) begin
      if (a_valid && (!b_valid || last_b)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt          <= 5'd0;
      last_b       <= 1'b1;
      conflict_cnt <= 16'd0;
      wEnable      <= 1'b0;
      dR           <= 5'd0;
      wData        <= 32'd0;
    end else begin
      unique case (state)
        CLEAR: begin
          wEnable <= 1'b1;
          dR      <= cnt;
          wData   <= 32'd0;
          cnt     <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (both && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
          end
          if (acc_a) begin
            dR      <= a_reg;
            wData   <= a_data;
            wEnable <= (a_reg != 5'd0);
            last_b  <= 1'b0;
          end else if (acc_b) begin
            dR      <= b_reg;
            wData   <= b_data;
            wEnable <= (b_reg != 5'd0);
            last_b  <= 1'b1;
          end else begin
            wEnable <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
